// File: rtl/mem_read_arbiter_if.sv
// AXI-style read address and read data channel bundles
// shared by the caches, the arbiter and the memory model.
interface axi_read_address #(
  parameter int AW = 32
);
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [3:0]    arid;

  modport master (
    output arvalid, araddr, arlen, arid,
    input  arready
  );
  modport slave (
    input  arvalid, araddr, arlen, arid,
    output arready
  );
endinterface

interface axi_read_data #(
  parameter int DW = 32
);
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;

  modport master (
    input  rvalid, rdata,
    output rready
  );
  modport slave (
    output rvalid, rdata,
    input  rready
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Two-requester read arbiter: d-cache (0) and i-cache (1) share one read port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default d-cache wins.
module mem_read_arbiter #(
  parameter int MAX_BEATS = 16
) (
  input logic             clk,
  input logic             rst_n,
  axi_read_address.slave  dc_read_address,
  axi_read_data.slave     dc_read_data,
  axi_read_address.slave  ic_read_address,
  axi_read_data.slave     ic_read_data,
  axi_read_address.master mem_read_address,
  axi_read_data.master    mem_read_data
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t        state;
  logic          grant;
  logic [CW-1:0] beats_left;

  logic       dc_req;
  logic       ic_req;
  logic       winner;
  logic [7:0] win_len;
  logic       len_ok;
  logic       in_addr;
  logic       in_data;
  logic       g_arvalid;
  logic       g_rready;
  logic       r_hs;
  logic       unused_id;

  assign dc_req = dc_read_address.arvalid;
  assign ic_req = ic_read_address.arvalid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant;

  assign winner = (dc_req & ic_req) ? ~last_grant : ic_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && (dc_req | ic_req)) begin
      last_grant <= winner;
    end
  end
`else
  assign winner = ic_req & ~dc_req;
`endif

  assign win_len = winner ? ic_read_address.arlen
                          : dc_read_address.arlen;
  // Out-of-range lengths still handshake but carry no beats.
  assign len_ok = (win_len != 8'd0) &&
                  (int'(win_len) <= MAX_BEATS);

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);

  assign g_arvalid = grant ? ic_read_address.arvalid
                           : dc_read_address.arvalid;
  assign g_rready  = grant ? ic_read_data.rready
                           : dc_read_data.rready;
  assign r_hs      = mem_read_data.rvalid & g_rready;

  assign mem_read_address.arvalid = in_addr & g_arvalid;
  assign mem_read_address.araddr  = grant ? ic_read_address.araddr
                                          : dc_read_address.araddr;
  assign mem_read_address.arlen   = grant ? ic_read_address.arlen
                                          : dc_read_address.arlen;
  assign mem_read_address.arid    = {3'b000, grant};

  assign dc_read_address.arready =
    in_addr & ~grant & mem_read_address.arready;
  assign ic_read_address.arready =
    in_addr & grant & mem_read_address.arready;

  assign dc_read_data.rvalid = in_data & ~grant & mem_read_data.rvalid;
  assign ic_read_data.rvalid = in_data & grant & mem_read_data.rvalid;
  assign dc_read_data.rdata  = mem_read_data.rdata;
  assign ic_read_data.rdata  = mem_read_data.rdata;
  assign mem_read_data.rready = in_data & g_rready;

  assign unused_id = ^{dc_read_address.arid, ic_read_address.arid};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      beats_left <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dc_req | ic_req) begin
            state      <= ADDR;
            grant      <= winner;
            beats_left <= len_ok ? CW'(win_len) : '0;
          end
        end
        ADDR: begin
          if (!g_arvalid) begin
            state <= IDLE;
          end else if (mem_read_address.arready) begin
            state <= (beats_left == '0) ? IDLE : DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            beats_left <= beats_left - CW'(1);
            if (beats_left == CW'(1)) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed vector table,
// grant-order sequence and randomized traffic against a transaction model.
module tb_mem_read_arbiter;

  localparam int MAXB = 16;

  logic clk;
  logic rst_n;

  axi_read_address dc_ar ();
  axi_read_data    dc_rd ();
  axi_read_address ic_ar ();
  axi_read_data    ic_rd ();
  axi_read_address mem_ar ();
  axi_read_data    mem_rd ();

  mem_read_arbiter #(.MAX_BEATS(MAXB)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dc_read_address  (dc_ar),
    .dc_read_data     (dc_rd),
    .ic_read_address  (ic_ar),
    .ic_read_data     (ic_rd),
    .mem_read_address (mem_ar),
    .mem_read_data    (mem_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_run;
  int n_fail;

  typedef struct {
    bit rst, dv, iv;
    int dl, il;
    bit mar, mrv;
    bit mav, id, dar, iar, drv, irv, mrr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    bit rst, bit dv, bit iv, int dl, int il, bit mar, bit mrv,
    bit mav, bit id, bit dar, bit iar, bit drv, bit irv, bit mrr);
    vec_t v;
    v.rst = rst; v.dv = dv; v.iv = iv; v.dl = dl; v.il = il;
    v.mar = mar; v.mrv = mrv; v.mav = mav; v.id = id;
    v.dar = dar; v.iar = iar; v.drv = drv; v.irv = irv; v.mrr = mrr;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit rst, bit dv, bit iv, int dl, int il,
                       bit mar, bit mrv, bit drr, bit irr);
    rst_n          = rst;
    dc_ar.arvalid  = dv;
    dc_ar.arlen    = 8'(dl);
    ic_ar.arvalid  = iv;
    ic_ar.arlen    = 8'(il);
    mem_ar.arready = mar;
    mem_rd.rvalid  = mrv;
    mem_rd.rdata   = $urandom;
    dc_rd.rready   = drr;
    ic_rd.rready   = irr;
  endtask

  function automatic int pick(bit d, bit i, int last);
    if (d && i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return 1 - last;
`else
      return 0;
`endif
    end
    return d ? 0 : 1;
  endfunction

  task automatic build_table();
    // reset state
    tv.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    // single i-cache burst, ARREADY after 2 cycles
    tv.push_back(mk(1,0,1,0,4,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,0,1,0,4,0,0, 1,1,0,0,0,0,0));
    tv.push_back(mk(1,0,1,0,4,0,0, 1,1,0,0,0,0,0));
    tv.push_back(mk(1,0,1,0,4,1,0, 1,1,0,1,0,0,0));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(1,0,0,0,0,0,1, 0,0,0,0,0,1,1));
    tv.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    // tie: d-cache 8 beats, then i-cache 2 cycles after last beat
    tv.push_back(mk(1,1,1,8,4,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,1,8,4,1,0, 1,0,1,0,0,0,0));
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(1,0,1,0,4,0,1, 0,0,0,0,1,0,1));
    tv.push_back(mk(1,0,1,0,4,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,0,1,0,4,0,0, 1,1,0,0,0,0,0));
    tv.push_back(mk(1,0,1,0,4,1,0, 1,1,0,1,0,0,0));
    // gapped beats at relative cycles 0,3,4,9
    for (int c = 0; c < 10; c++) begin
      bit b;
      b = (c == 0 || c == 3 || c == 4 || c == 9);
      tv.push_back(mk(1,0,0,0,0,0,b, 0,0,0,0,0,b,1));
    end
    tv.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    // reset after 2 of 4 beats, then fresh i-cache burst
    tv.push_back(mk(1,1,0,4,0,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,0,4,0,1,0, 1,0,1,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,1, 0,0,0,0,1,0,1));
    tv.push_back(mk(1,0,0,0,0,0,1, 0,0,0,0,1,0,1));
    tv.push_back(mk(0,0,0,0,0,0,1, 0,0,0,0,1,0,1));
    tv.push_back(mk(1,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,0,1,0,4,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,0,1,0,4,1,0, 1,1,0,1,0,0,0));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(1,0,0,0,0,0,1, 0,0,0,0,0,1,1));
    tv.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    // granted d-cache drops ARVALID; i-cache ARLEN=0
    tv.push_back(mk(1,1,1,4,0,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,1,4,0,0,0, 1,0,0,0,0,0,0));
    tv.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,0,1,0,0,0,0, 1,1,0,0,0,0,0));
    tv.push_back(mk(1,0,1,0,0,1,0, 1,1,0,1,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    // ARLEN above MAX_BEATS
    tv.push_back(mk(1,1,0,17,0,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,0,17,0,1,0, 1,0,1,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,1, 0,0,0,0,0,0,0));
  endtask

  task automatic do_reset();
    drive(0,0,0,0,0,0,0,1,1);
    step();
    step();
  endtask

  task automatic run_table();
    foreach (tv[k]) begin
      drive(tv[k].rst, tv[k].dv, tv[k].iv, tv[k].dl, tv[k].il,
            tv[k].mar, tv[k].mrv, 1'b1, 1'b1);
      dc_ar.araddr = 32'h0000_2000;
      ic_ar.araddr = 32'h0000_0100;
      #1;
      chk($sformatf("v%0d mav", k), mem_ar.arvalid, tv[k].mav);
      if (tv[k].mav) begin
        chk($sformatf("v%0d arid", k), mem_ar.arid, {3'b0, tv[k].id});
        chk($sformatf("v%0d araddr", k), mem_ar.araddr,
            tv[k].id ? 32'h100 : 32'h2000);
      end
      chk($sformatf("v%0d dc_arready", k), dc_ar.arready, tv[k].dar);
      chk($sformatf("v%0d ic_arready", k), ic_ar.arready, tv[k].iar);
      chk($sformatf("v%0d dc_rvalid", k), dc_rd.rvalid, tv[k].drv);
      chk($sformatf("v%0d ic_rvalid", k), ic_rd.rvalid, tv[k].irv);
      chk($sformatf("v%0d mem_rready", k), mem_rd.rready, tv[k].mrr);
      step();
    end
  endtask

  task automatic run_order();
    bit want_d, want_i;
    int got[$];
    int exp_ord[4];
    exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 0; exp_ord[3] = 1;
    do_reset();
    want_d = 1'b1;
    want_i = 1'b1;
    for (int c = 0; c < 100 && got.size() < 4; c++) begin
      drive(1, want_d, want_i, 1, 1, 1, 1, 1, 1);
      #1;
      if (mem_ar.arvalid && mem_ar.arready) begin
        got.push_back(int'(mem_ar.arid));
        if (mem_ar.arid[0]) want_i = 1'b0;
        else want_d = 1'b0;
      end
      step();
      if (!want_d && !want_i) begin
        want_d = 1'b1;
        want_i = 1'b1;
      end
    end
    n_run++;
    if (got.size() < 4) begin
      n_fail++;
      $display("FAIL order timeout: got %0d grants expected 4",
               got.size());
    end else begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("order%0d", i), got[i], exp_ord[i]);
    end
  endtask

  task automatic run_random(int cycles);
    bit want[2];
    logic [31:0] addr[2];
    int len[2];
    int owner, last, due;
    bit accepted;
    bit mar, mrv, rr[2];
    bit addr_ph, data_ph;
    do_reset();
    owner = -1; last = 1; due = 0; accepted = 1'b0;
    want[0] = 0; want[1] = 0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!want[i] && $urandom_range(0, 3) == 0) begin
          want[i] = 1'b1;
          addr[i] = $urandom;
          len[i]  = $urandom_range(0, MAXB + 2);
        end
        rr[i] = ($urandom_range(0, 9) < 7);
      end
      addr_ph = (owner >= 0) && !accepted;
      data_ph = (owner >= 0) && accepted;
      mar = $urandom_range(0, 1);
      mrv = data_ph ? ($urandom_range(0, 9) < 6)
                    : ($urandom_range(0, 4) == 0);
      drive(1, want[0], want[1], len[0], len[1], mar, mrv, rr[0], rr[1]);
      dc_ar.araddr = addr[0];
      ic_ar.araddr = addr[1];
      dc_ar.arid   = 4'($urandom);
      ic_ar.arid   = 4'($urandom);
      #1;
      chk("rnd mav", mem_ar.arvalid, addr_ph);
      if (addr_ph) begin
        chk("rnd arid", mem_ar.arid, owner);
        chk("rnd araddr", mem_ar.araddr, addr[owner]);
        chk("rnd arlen", mem_ar.arlen, len[owner]);
      end
      chk("rnd dc_arready", dc_ar.arready, addr_ph && owner == 0 && mar);
      chk("rnd ic_arready", ic_ar.arready, addr_ph && owner == 1 && mar);
      chk("rnd dc_rvalid", dc_rd.rvalid, data_ph && owner == 0 && mrv);
      chk("rnd ic_rvalid", ic_rd.rvalid, data_ph && owner == 1 && mrv);
      chk("rnd mem_rready", mem_rd.rready, data_ph && rr[owner]);
      chk("rnd rdata", {dc_rd.rdata ^ ic_rd.rdata}, 32'h0);
      chk("rnd dc_rdata", dc_rd.rdata, mem_rd.rdata);
      if (owner < 0) begin
        if (want[0] || want[1]) begin
          owner = pick(want[0], want[1], last);
          last = owner;
          accepted = 1'b0;
        end
      end else if (!accepted) begin
        if (mar) begin
          want[owner] = 1'b0;
          if (len[owner] >= 1 && len[owner] <= MAXB) begin
            accepted = 1'b1;
            due = len[owner];
          end else begin
            owner = -1;
          end
        end
      end else if (mrv && rr[owner]) begin
        due--;
        if (due == 0) owner = -1;
      end
      step();
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    dc_ar.araddr = '0; dc_ar.arid = '0;
    ic_ar.araddr = '0; ic_ar.arid = '0;
    do_reset();
    build_table();
    run_table();
    run_order();
    run_random(3000);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
